refill_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline in the cache build.

---
 rtl/refill_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_refill_stall_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/refill_stall_ctrl.sv
// Stall/flush sequencer: arbitrates the shared memory port between I/D line refills (dirty writeback first)
// and merges miss, branch-flush and load-use into per-stage enables; port outputs are registered-state decodes, enables are combinational.
module refill_stall_ctrl #(
    parameter int BEATS = 4,
    parameter int CNT_W = 32,
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_delay,
    input  logic             branch_flush,
    input  logic             ic_miss,
    input  logic             dc_miss,
    input  logic             dc_dirty,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_dc,
    output logic [BW-1:0]    mem_beat,
    output logic             ic_fill_done,
    output logic             dc_fill_done,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DC_WB,
        S_DC_FILL,
        S_DC_DONE,
        S_IC_FILL,
        S_IC_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0] stall_q;
    logic             last_beat;

    assign last_beat = (beat_q == BW'(BEATS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Beat counter wraps to 0 on the last beat, so the next phase starts at 0.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (dc_miss) begin
                    state_d = dc_dirty ? S_DC_WB : S_DC_FILL;
                end else if (ic_miss) begin
                    state_d = S_IC_FILL;
                end
            end
            S_DC_WB, S_DC_FILL, S_IC_FILL: begin
                if (mem_ready) begin
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        case (state_q)
                            S_DC_WB:   state_d = S_DC_FILL;
                            S_DC_FILL: state_d = S_DC_DONE;
                            default:   state_d = S_IC_DONE;
                        endcase
                    end
                end
            end
            S_DC_DONE, S_IC_DONE: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    assign mem_req      = (state_q == S_DC_WB) || (state_q == S_DC_FILL) || (state_q == S_IC_FILL);
    assign mem_we       = (state_q == S_DC_WB);
    assign mem_sel_dc   = (state_q == S_DC_WB) || (state_q == S_DC_FILL);
    assign mem_beat     = beat_q;
    assign ic_fill_done = (state_q == S_IC_DONE);
    assign dc_fill_done = (state_q == S_DC_DONE);

    logic dc_busy, ic_busy;
    assign dc_busy = dc_miss || (state_q == S_DC_WB) || (state_q == S_DC_FILL) || (state_q == S_DC_DONE);
    assign ic_busy = ic_miss || (state_q == S_IC_FILL) || (state_q == S_IC_DONE);

    // A D-side miss freezes everything; a branch flush beats an I-side stall.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        if (dc_busy) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else if (branch_flush) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (ic_busy || load_delay) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (!PCWrite && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_refill_stall_ctrl.sv
// Bench for refill_stall_ctrl: acts as both caches and memory; expected beats and fill pulses are queued when a miss is raised.
module tb_refill_stall_ctrl;
    localparam int BEATS = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic load_delay, branch_flush, ic_miss, dc_miss, dc_dirty, mem_ready;
    logic mem_req, mem_we, mem_sel_dc;
    logic [1:0] mem_beat;
    logic ic_fill_done, dc_fill_done;
    logic PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
    logic IF_ID_Flush, ID_EX_Flush;
    logic [CNT_W-1:0] stall_cycles;

    refill_stall_ctrl #(.BEATS(BEATS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .load_delay(load_delay), .branch_flush(branch_flush),
        .ic_miss(ic_miss), .dc_miss(dc_miss), .dc_dirty(dc_dirty), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_dc(mem_sel_dc), .mem_beat(mem_beat),
        .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Write(MEM_WB_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    logic [4:0] wr;
    logic [1:0] fl;
    assign wr = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write};
    assign fl = {IF_ID_Flush, ID_EX_Flush};

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_beats[$];
    logic [1:0] exp_done[$];   // {ic, dc}
    logic n_ic = 0, n_dc = 0, n_dirty = 0, n_bf = 0, n_ld = 0;
    logic drop_ic = 0, drop_dc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_burst(input logic we, input logic sel);
        for (int i = 0; i < BEATS; i++) exp_beats.push_back({we, sel, 2'(i)});
    endtask

    // One clock: drive at negedge, observe 1ns later (well before the next posedge).
    task automatic cyc(input logic rdy);
        logic [3:0] eb;
        logic [1:0] ed;
        @(negedge clk);
        if (drop_ic) begin n_ic = 0; drop_ic = 0; end
        if (drop_dc) begin n_dc = 0; n_dirty = 0; drop_dc = 0; end
        ic_miss = n_ic; dc_miss = n_dc; dc_dirty = n_dirty;
        branch_flush = n_bf; load_delay = n_ld; mem_ready = rdy;
        #1;
        if (mem_req && mem_ready) begin
            check("beat_pending", exp_beats.size() > 0, 1);
            if (exp_beats.size() > 0) begin
                eb = exp_beats.pop_front();
                check("beat_we_sel_idx", {mem_we, mem_sel_dc, mem_beat}, eb);
            end
        end
        if (ic_fill_done || dc_fill_done) begin
            check("done_pending", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) begin
                ed = exp_done.pop_front();
                check("done_src", {ic_fill_done, dc_fill_done}, ed);
            end
            if (ic_fill_done) drop_ic = 1;
            if (dc_fill_done) drop_dc = 1;
        end
    endtask

    task automatic run_idle(input string tag, input logic alt);
        int k;
        k = 0;
        while ((n_ic || n_dc || drop_ic || drop_dc) && k < 200) begin
            cyc(alt ? logic'(k[0]) : 1'b1);
            k++;
        end
        check({tag, "_timeout"}, k < 200, 1);
        check({tag, "_beats_left"}, exp_beats.size(), 0);
        check({tag, "_done_left"}, exp_done.size(), 0);
    endtask

    initial begin
        int k, reqs, done_at, bad;
        reset_n = 0;
        {ic_miss, dc_miss, dc_dirty, branch_flush, load_delay, mem_ready} = '0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        cyc(0);
        check("rst_writes", wr, 5'h1f);
        check("rst_flush", fl, 2'b00);
        check("rst_mem_req", mem_req, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_beat", mem_beat, 0);

        // I-cache refill, memory ready every cycle
        n_ic = 1; push_burst(0, 0); exp_done.push_back(2'b10);
        k = 0; reqs = 0; done_at = -1; bad = 0;
        while ((n_ic || drop_ic) && k < 50) begin
            cyc(1);
            if (mem_req) reqs++;
            if (ic_fill_done) done_at = k;
            if (ic_miss && (PCWrite !== 1'b0 || ID_EX_Flush !== 1'b1)) bad++;
            k++;
        end
        check("ic_timeout", k < 50, 1);
        check("ic_req_cycles", reqs, 4);
        check("ic_done_cycle", done_at, 5);
        check("ic_stall_hold", bad, 0);
        check("ic_stall_cycles", stall_cycles, 6);
        check("ic_after_writes", wr, 5'h1f);

        // Dirty D-cache miss, memory ready every other cycle; flush/load-use held off
        n_dc = 1; n_dirty = 1; push_burst(1, 1); push_burst(0, 1); exp_done.push_back(2'b01);
        k = 0; bad = 0;
        while ((n_dc || drop_dc) && k < 100) begin
            n_bf = (k == 3); n_ld = (k == 4);
            cyc(logic'(k[0]));
            if (dc_miss && (wr !== 5'h00 || fl !== 2'b00)) bad++;
            k++;
        end
        n_bf = 0; n_ld = 0;
        check("dc_timeout", k < 100, 1);
        check("dc_freeze", bad, 0);
        check("dc_after_writes", wr, 5'h1f);
        check("dc_beats_left", exp_beats.size(), 0);

        // Both misses together: D first, then I
        n_ic = 1; n_dc = 1; push_burst(0, 1); push_burst(0, 0);
        exp_done.push_back(2'b01); exp_done.push_back(2'b10);
        run_idle("both", 0);

        // Branch flush during I fill; fill still completes
        n_ic = 1; push_burst(0, 0); exp_done.push_back(2'b10);
        cyc(1); cyc(1);
        n_bf = 1; cyc(1); n_bf = 0;
        check("bf_pc_flush", {PCWrite, IF_ID_Flush, ID_EX_Flush}, 3'b111);
        check("bf_mem_req", mem_req, 1);
        run_idle("bf", 0);

        // Load-use alone
        n_ld = 1; cyc(0); n_ld = 0;
        check("ld_writes", wr, 5'b00111);
        check("ld_flush", fl, 2'b01);

        // mem_ready while idle is ignored
        cyc(1); cyc(1); cyc(1);
        check("idle_rdy_req", mem_req, 0);
        check("idle_rdy_beat", mem_beat, 0);

        // Saturating stall counter
        n_ld = 1; repeat (20) cyc(0); n_ld = 0; cyc(0);
        check("stall_sat", stall_cycles, 15);

        // Reset at beat 2 of DC_FILL
        n_dc = 1; n_dirty = 0; push_burst(0, 1);
        k = 0;
        while (!(mem_req && mem_beat == 2) && k < 20) begin cyc(1); k++; end
        check("rstmid_reach", mem_beat, 2);
        reset_n = 0;
        #1;
        check("rstmid_req", mem_req, 0);
        check("rstmid_beat", mem_beat, 0);
        check("rstmid_stall", stall_cycles, 0);
        check("rstmid_done", {ic_fill_done, dc_fill_done}, 2'b00);
        exp_beats.delete();
        n_dc = 0;
        cyc(0);
        reset_n = 1;
        repeat (6) cyc(1);
        check("rstmid_after_req", mem_req, 0);
        check("rstmid_after_writes", wr, 5'h1f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
